// File: rtl/banked_reg_file_pkg.sv
// Shared constants and FSM state type for the banked register file.
// The clear sequencer and the top both import this package.
package banked_reg_file_pkg;

  localparam int DEF_NUM_REGS   = 4;
  localparam int DEF_NUM_BANKS  = 2;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/banked_reg_file_if.sv
// Register-file access bus: bank select, two read ports, one write port,
// bank-clear request and status back to the requester.
interface banked_reg_file_if import banked_reg_file_pkg::*; #(
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int NUM_BANKS  = DEF_NUM_BANKS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int BW = $clog2(NUM_BANKS);

  logic [BW-1:0]         bank_i;
  logic [AW-1:0]         rs_addr_i;
  logic [AW-1:0]         rt_addr_i;
  logic [AW-1:0]         wa_addr_i;
  logic                  wen_i;
  logic [DATA_WIDTH-1:0] write_data_i;
  logic                  clr_i;
  logic [BW-1:0]         clr_bank_i;
  logic [DATA_WIDTH-1:0] rs_val_o;
  logic [DATA_WIDTH-1:0] rt_val_o;
  logic                  busy_o;
  logic                  wr_drop_o;

  modport master (
    output bank_i, rs_addr_i, rt_addr_i, wa_addr_i, wen_i, write_data_i,
           clr_i, clr_bank_i,
    input  rs_val_o, rt_val_o, busy_o, wr_drop_o
  );

  modport slave (
    input  bank_i, rs_addr_i, rt_addr_i, wa_addr_i, wen_i, write_data_i,
           clr_i, clr_bank_i,
    output rs_val_o, rt_val_o, busy_o, wr_drop_o
  );
endinterface

// File: rtl/banked_reg_file_clear_fsm.sv
// Bank-clear sequencer: latches the requested bank and walks a pointer
// across every register of it, one register per clock.
module bank_clear_fsm import banked_reg_file_pkg::*; #(
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  localparam int AW = $clog2(NUM_REGS),
  localparam int BW = $clog2(NUM_BANKS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic [BW-1:0] clr_bank_i,
  output logic          busy_o,
  output logic          clr_en_o,
  output logic [BW-1:0] clr_bank_o,
  output logic [AW-1:0] clr_addr_o
);
  localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [BW-1:0] bank_q, bank_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      bank_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      bank_q  <= bank_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    bank_d  = bank_q;
    case (state_q)
      IDLE: begin
        if (clr_i) begin
          state_d = CLEAR;
          ptr_d   = '0;
          bank_d  = clr_bank_i;
        end
      end
      CLEAR: begin
        // Leave on the last register so the pointer never wraps within a clear.
        if (ptr_q == LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o     = (state_q == CLEAR);
  assign clr_en_o   = (state_q == CLEAR);
  assign clr_bank_o = bank_q;
  assign clr_addr_o = ptr_q;

endmodule

// File: rtl/banked_reg_file.sv
// Banked register file with two combinational read ports, one write port
// with write-through, and a background per-bank clear.
module banked_reg_file import banked_reg_file_pkg::*; #(
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int NUM_BANKS  = DEF_NUM_BANKS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  banked_reg_file_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int BW = $clog2(NUM_BANKS);

  logic                  busy;
  logic                  clr_en;
  logic [BW-1:0]         clr_bank;
  logic [AW-1:0]         clr_addr;
  logic                  clr_accept;
  logic                  wr_ok;
  logic                  wr_drop_q;
  logic [DATA_WIDTH-1:0] rd_mem [NUM_BANKS][NUM_REGS];

  bank_clear_fsm #(
    .NUM_REGS  (NUM_REGS),
    .NUM_BANKS (NUM_BANKS)
  ) u_clear_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (bus.clr_i),
    .clr_bank_i (bus.clr_bank_i),
    .busy_o     (busy),
    .clr_en_o   (clr_en),
    .clr_bank_o (clr_bank),
    .clr_addr_o (clr_addr)
  );

  // Writes lose to an active clear and to the cycle that starts one;
  // gating with rst_n keeps write-through from leaking out during reset.
  assign clr_accept = bus.clr_i & ~busy;
  assign wr_ok      = rst_n & bus.wen_i & ~busy & ~clr_accept;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      for (gj = 0; gj < NUM_REGS; gj++) begin : g_reg
        logic [DATA_WIDTH-1:0] cell_q;
        logic                  hit_clr;
        logic                  hit_wr;

        assign hit_clr = clr_en && (clr_bank == BW'(gi)) && (clr_addr == AW'(gj));
        assign hit_wr  = wr_ok && (bus.bank_i == BW'(gi)) && (bus.wa_addr_i == AW'(gj));

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)       cell_q <= '0;
          else if (hit_clr) cell_q <= '0;
          else if (hit_wr)  cell_q <= bus.write_data_i;
        end

        assign rd_mem[gi][gj] = cell_q;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_drop_q <= 1'b0;
    else        wr_drop_q <= bus.wen_i & ~wr_ok;
  end

  assign bus.rs_val_o  = (wr_ok && bus.rs_addr_i == bus.wa_addr_i) ? bus.write_data_i
                                                                  : rd_mem[bus.bank_i][bus.rs_addr_i];
  assign bus.rt_val_o  = (wr_ok && bus.rt_addr_i == bus.wa_addr_i) ? bus.write_data_i
                                                                  : rd_mem[bus.bank_i][bus.rt_addr_i];
  assign bus.busy_o    = busy;
  assign bus.wr_drop_o = wr_drop_q;

endmodule

// File: doc/banked_reg_file.md
BANKED_REG_FILE -- requirements
Module: banked_reg_file

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 4, registers per bank; a power of two, at least 2.
REQ-002 The block SHALL have parameter NUM_BANKS, default 2, number of banks; a power of two, at least 2.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 8, bits per register.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port bank_i, input, $clog2(NUM_BANKS), bank for reads and writes.
REQ-007 The block SHALL have port rs_addr_i, input, $clog2(NUM_REGS), read port A address.
REQ-008 The block SHALL have port rt_addr_i, input, $clog2(NUM_REGS), read port B address.
REQ-009 The block SHALL have port wa_addr_i, input, $clog2(NUM_REGS), write address.
REQ-010 The block SHALL have port wen_i, input, 1, write enable.
REQ-011 The block SHALL have port write_data_i, input, DATA_WIDTH, write data.
REQ-012 The block SHALL have port clr_i, input, 1, single-cycle request to clear one bank.
REQ-013 The block SHALL have port clr_bank_i, input, $clog2(NUM_BANKS), bank to clear; sampled with clr_i.
REQ-014 The block SHALL have port rs_val_o, output, DATA_WIDTH, read port A data.
REQ-015 The block SHALL have port rt_val_o, output, DATA_WIDTH, read port B data.
REQ-016 The block SHALL have port busy_o, output, 1, high while a bank clear is in progress.
REQ-017 The block SHALL have port wr_drop_o, output, 1, registered one-cycle pulse when an asserted wen_i was ignored.

Function
REQ-018 Reads SHALL be combinational: rs_val_o = reg[bank_i][rs_addr_i]; likewise rt_val_o with rt_addr_i.
REQ-019 With wen_i=1 and busy_o=0, write_data_i SHALL be stored to reg[bank_i][wa_addr_i] at the next rising edge.
REQ-020 Write-through: when wen_i=1, busy_o=0 and a read address equals wa_addr_i, that read output SHALL show write_data_i in the same cycle.
REQ-021 Clear FSM states SHALL be IDLE and CLEAR; reset state IDLE.
REQ-022 In IDLE, clr_i=1 SHALL latch clr_bank_i, zero the pointer, and move to CLEAR at the next edge.
REQ-023 In CLEAR, each edge SHALL write 0 to reg[latched bank][pointer] and increment the pointer.
REQ-024 After the write at pointer NUM_REGS-1, the FSM SHALL return to IDLE; a clear therefore takes exactly NUM_REGS cycles in CLEAR.
REQ-025 busy_o SHALL equal (state == CLEAR).
REQ-026 A clr_i asserted while busy_o=1 SHALL be ignored, not queued.
REQ-027 A wen_i asserted while busy_o=1, or in the IDLE cycle that accepts clr_i, SHALL be ignored (no write, no write-through), whatever bank it addresses.
REQ-028 Each ignored write SHALL cause wr_drop_o=1 for the following cycle.
REQ-029 Reads during CLEAR SHALL return stored contents; cleared registers read 0 from the cycle after their clear edge.
REQ-030 The pointer SHALL not wrap past NUM_REGS-1 within one clear.

Reset
REQ-031 rst_n=0 SHALL asynchronously set every register in every bank to 0.
REQ-032 rst_n=0 SHALL asynchronously set state=IDLE, pointer=0, latched bank=0 and wr_drop_o=0.
REQ-033 While rst_n=0, rs_val_o=rt_val_o=0 and busy_o=0.
REQ-034 Reset asserted mid-clear SHALL abort the clear; after release the FSM is IDLE with all registers 0.

Structure
REQ-035 Package banked_reg_file_pkg SHALL hold the FSM state enum typedef and the default parameter constants.
REQ-036 The clear FSM, its pointer and bank latch SHALL be the sub-module bank_clear_fsm, with outputs busy, clear-enable, clear bank and clear address.
REQ-037 Storage, write arbitration and read muxing SHALL stay in banked_reg_file.

Verification
REQ-038 Write 0xA5 to bank1/reg2, then read bank1 rs=2 and bank0 rs=2 -> 0xA5 and 0x00.
REQ-039 wen_i=1, wa=3, rs=3, data 0x3C in one cycle -> rs_val_o=0x3C in that same cycle; the stored value is 0x3C after the edge.
REQ-040 Fill bank0 with 0x11..0x44, pulse clr_i with clr_bank_i=0 -> busy_o high exactly 4 cycles; bank0 then reads 0x00; bank1 is unchanged.
REQ-041 wen_i=1 during CLEAR -> no register changes and wr_drop_o pulses 1 the next cycle; a clr_i during CLEAR is ignored, shown by busy_o falling after 4 cycles.
REQ-042 Drop rst_n after 2 cycles of CLEAR -> busy_o=0 immediately; after release all registers read 0.
REQ-043 With NUM_REGS=8, NUM_BANKS=4, DATA_WIDTH=16: write 0xBEEF to bank3/reg7, then clear bank3 -> busy_o high 8 cycles and reg7 reads 0.
